// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Optional build macro: LSU_ACCESS_TIMEOUT_EN (response-wait timeout).
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } lane_t;

    function automatic logic is_aligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b1;
        case (f3)
            F3_H, F3_HU: ok = ~off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte enables and lane-replicated data for a store.
    function automatic lane_t store_lane(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] d
    );
        lane_t l;
        l.be   = 4'b0001 << off;
        l.data = {4{d[7:0]}};
        case (f3[1:0])
            2'b01: begin
                l.be   = off[1] ? 4'b1100 : 4'b0011;
                l.data = {2{d[15:0]}};
            end
            2'b10: begin
                l.be   = 4'b1111;
                l.data = d;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory valid/ready port between the load/store unit and memory.
// Optional build macro: none used here (see load_store_unit).
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [3:0]            mem_req_be;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr,
        output mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr,
        input  mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Lane select and sign/zero extension of a raw memory word.
// Optional build macro: none used here (see load_store_unit).
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{offset, 3'b000} +: 8];
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_BU:   data = {24'h0, b};
            F3_HU:   data = {16'h0, h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one access per instruction, stalls while busy.
// Optional build macro: LSU_ACCESS_TIMEOUT_EN (response-wait timeout).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    load_store_unit_if.master     mem,
    output logic                  lsu_stall,
    output logic [DATA_WIDTH-1:0] wb_load_data,
    output logic                  wb_load_valid,
    output logic                  misaligned_exc,
    output logic                  bus_error
);
    lsu_state_t state;
    logic start;
    logic aligned;
    lane_t lane;

    logic                  we_q;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic                  req_valid;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] ext;

    assign start   = ex_valid & (ex_mem_read | ex_mem_write);
    assign aligned = is_aligned(ex_funct3, ex_addr[1:0]);
    assign lane    = store_lane(ex_funct3, ex_addr[1:0], ex_wdata);

    assign lsu_stall = (state == IDLE && start && aligned)
                     || state == REQ || state == WAIT_RSP;

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_we    = we_q;
    assign mem.mem_req_addr  = req_addr;
    assign mem.mem_req_wdata = req_wdata;
    assign mem.mem_req_be    = req_be;

    load_extend u_ext (
        .rdata  (mem.mem_rsp_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ext)
    );

`ifdef LSU_ACCESS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8)
                      ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic          berr_q;
    assign bus_error = berr_q;
`else
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            off_q          <= 2'b00;
            f3_q           <= 3'b000;
            req_valid      <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            req_be         <= 4'b0000;
            wb_load_data   <= '0;
            wb_load_valid  <= 1'b0;
            misaligned_exc <= 1'b0;
`ifdef LSU_ACCESS_TIMEOUT_EN
            cnt            <= '0;
            berr_q         <= 1'b0;
`endif
        end else begin
            wb_load_valid  <= 1'b0;
            misaligned_exc <= 1'b0;
`ifdef LSU_ACCESS_TIMEOUT_EN
            berr_q         <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start && aligned) begin
                        // Read wins when both read and write are set.
                        we_q      <= ex_mem_write & ~ex_mem_read;
                        off_q     <= ex_addr[1:0];
                        f3_q      <= ex_funct3;
                        req_addr  <= {ex_addr[DATA_WIDTH-1:2], 2'b00};
                        req_wdata <= lane.data;
                        req_be    <= lane.be;
                        req_valid <= 1'b1;
                        state     <= REQ;
                    end else if (start) begin
                        misaligned_exc <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem.mem_req_ready) begin
                        req_valid <= 1'b0;
`ifdef LSU_ACCESS_TIMEOUT_EN
                        cnt       <= '0;
`endif
                        if (we_q) begin
                            wb_load_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state         <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (mem.mem_rsp_valid) begin
                        wb_load_data  <= ext;
                        wb_load_valid <= 1'b1;
                        state         <= DONE;
                    end
`ifdef LSU_ACCESS_TIMEOUT_EN
                    else if (cnt == TMAX) begin
                        wb_load_data  <= '0;
                        wb_load_valid <= 1'b1;
                        berr_q        <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a completion scoreboard.
// Optional build macro: LSU_ACCESS_TIMEOUT_EN enables the timeout step.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_stall;
    logic [31:0] wb_load_data;
    logic        wb_load_valid;
    logic        misaligned_exc;
    logic        bus_error;

    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32)) mem ();

    load_store_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .mem            (mem),
        .lsu_stall      (lsu_stall),
        .wb_load_data   (wb_load_data),
        .wb_load_valid  (wb_load_valid),
        .misaligned_exc (misaligned_exc),
        .bus_error      (bus_error)
    );

    typedef struct {
        logic [31:0] data;
        logic        berr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_wb = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every completion pops exactly one expected result.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_load_valid === 1'b1) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", wb_load_data, e.data);
                chk("sb_berr", 32'(bus_error), 32'(e.berr));
            end
        end
    end

    task automatic access(
        input string       tag,
        input logic        rd,
        input logic        wr,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input int          rdy_wait,
        input logic        give_rsp,
        input logic [31:0] rdata,
        input int          exp_stall,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wd
    );
        int   stalls = 0;
        int   vcnt   = 0;
        logic pend   = 1'b0;
        logic done   = 1'b0;
        logic st;
        st = wr & ~rd;
        @(negedge clk);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = addr;
        ex_wdata     = wd;
        for (int c = 0; c < 50 && !done; c++) begin
            if (c > 0) @(negedge clk);
            mem.mem_rsp_valid = pend;
            mem.mem_rsp_rdata = pend ? rdata : 32'h0;
            pend = 1'b0;
            mem.mem_req_ready = 1'b0;
            if (mem.mem_req_valid) begin
                chk({tag, "_addr"}, mem.mem_req_addr, {addr[31:2], 2'b00});
                chk({tag, "_we"}, 32'(mem.mem_req_we), 32'(st));
                if (st) begin
                    chk({tag, "_be"}, 32'(mem.mem_req_be), 32'(exp_be));
                    chk({tag, "_wdata"}, mem.mem_req_wdata, exp_wd);
                end
                if (vcnt >= rdy_wait) begin
                    mem.mem_req_ready = 1'b1;
                    pend = give_rsp & ~st;
                end
                vcnt++;
            end
            #1;
            if (lsu_stall) stalls++;
            if (wb_load_valid) done = 1'b1;
        end
        ex_valid          = 1'b0;
        mem.mem_req_ready = 1'b0;
        mem.mem_rsp_valid = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stall"}, stalls, exp_stall);
        @(negedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(wb_load_valid), 32'd0);
        chk({tag, "_idle"}, 32'(lsu_stall), 32'd0);
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input logic [31:0] exp);
        exp_wb = exp;
        sb.push_back('{exp, 1'b0});
        access(tag, 1'b1, 1'b0, f3, addr, 32'h0, 0, 1'b1, rdata,
               3, 4'h0, 32'h0);
    endtask

    task automatic store(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int rdy_wait, input int exp_stall,
                         input logic [3:0] be, input logic [31:0] exp_wd);
        sb.push_back('{exp_wb, 1'b0});
        access(tag, 1'b0, 1'b1, f3, addr, wd, rdy_wait, 1'b0, 32'h0,
               exp_stall, be, exp_wd);
    endtask

    initial begin
        rst               = 1'b1;
        ex_valid          = 1'b0;
        ex_mem_read       = 1'b0;
        ex_mem_write      = 1'b0;
        ex_funct3         = 3'b000;
        ex_addr           = 32'h0;
        ex_wdata          = 32'h0;
        mem.mem_req_ready = 1'b0;
        mem.mem_rsp_valid = 1'b0;
        mem.mem_rsp_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(mem.mem_req_valid), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_load_valid), 32'd0);
        chk("rst_wb_data", wb_load_data, 32'h0);
        chk("rst_mis", 32'(misaligned_exc), 32'd0);
        chk("rst_berr", 32'(bus_error), 32'd0);
        rst = 1'b0;

        load("lw", F3_W, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        load("lb", F3_B, 32'h103, 32'h80FF0000, 32'hFFFFFF80);
        load("lbu", F3_BU, 32'h103, 32'h80FF0000, 32'h00000080);
        load("lhu", F3_HU, 32'h102, 32'h80FF0000, 32'h000080FF);
        load("lh", F3_H, 32'h102, 32'h80FF0000, 32'hFFFF80FF);
        load("lb0", F3_B, 32'h104, 32'h0000007F, 32'h0000007F);

        store("sb", F3_B, 32'h201, 32'h000000AB, 4, 6, 4'b0010, 32'hABABABAB);
        store("sh", F3_H, 32'h206, 32'h0000BEEF, 0, 2, 4'b1100, 32'hBEEFBEEF);
        store("sw", F3_W, 32'h204, 32'h11223344, 0, 2, 4'b1111, 32'h11223344);

        // Misaligned word load: dropped, single exception pulse.
        @(negedge clk);
        ex_valid     = 1'b1;
        ex_mem_read  = 1'b1;
        ex_mem_write = 1'b0;
        ex_funct3    = F3_W;
        ex_addr      = 32'h102;
        #1;
        chk("mis_stall0", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("mis_pulse", 32'(misaligned_exc), 32'd1);
        chk("mis_noreq", 32'(mem.mem_req_valid), 32'd0);
        chk("mis_stall1", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        #1;
        chk("mis_once", 32'(misaligned_exc), 32'd0);
        chk("mis_noreq2", 32'(mem.mem_req_valid), 32'd0);

        // Reset while waiting for a load response.
        @(negedge clk);
        ex_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_funct3   = F3_W;
        ex_addr     = 32'h300;
        @(negedge clk);
        chk("rw_req", 32'(mem.mem_req_valid), 32'd1);
        mem.mem_req_ready = 1'b1;
        @(negedge clk);
        mem.mem_req_ready = 1'b0;
        #1;
        chk("rw_wait_stall", 32'(lsu_stall), 32'd1);
        chk("rw_wait_noreq", 32'(mem.mem_req_valid), 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        rst               = 1'b0;
        mem.mem_rsp_valid = 1'b1;
        mem.mem_rsp_rdata = 32'h12345678;
        #1;
        chk("rw_req_drop", 32'(mem.mem_req_valid), 32'd0);
        chk("rw_stall_drop", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        mem.mem_rsp_valid = 1'b0;
        #1;
        chk("rw_no_valid", 32'(wb_load_valid), 32'd0);
        chk("rw_data0", wb_load_data, 32'h0);
        exp_wb = 32'h0;

`ifdef LSU_ACCESS_TIMEOUT_EN
        sb.push_back('{32'h0, 1'b1});
        access("tmo", 1'b1, 1'b0, F3_W, 32'h400, 32'h0, 0, 1'b0,
               32'h0, 6, 4'h0, 32'h0);
`endif

        load("lw2", F3_W, 32'h010, 32'hCAFEF00D, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
